// File: rtl/data_packer_v2_pkg.sv
// Shared definitions for the trace data packer: condition codes, FSM states
// and the per-chain condition matcher.
package data_packer_pkg;

  typedef logic [7:0] cfg_byte_t;

  localparam cfg_byte_t COND_NONE     = 8'd0;
  localparam cfg_byte_t COND_LAST     = 8'd1;
  localparam cfg_byte_t COND_NOTLAST  = 8'd2;
  localparam cfg_byte_t COND_FIRST    = 8'd3;
  localparam cfg_byte_t COND_NOTFIRST = 8'd4;

  typedef logic [0:0] state_t;
  localparam state_t RUN  = 1'b0;
  localparam state_t TAIL = 1'b1;

  // Unknown codes never match, so a mis-programmed chain drops everything.
  function automatic logic cond_match(input cfg_byte_t code, input logic eof, input logic bof);
    case (code)
      COND_NONE:     cond_match = 1'b1;
      COND_LAST:     cond_match = eof;
      COND_NOTLAST:  cond_match = !eof;
      COND_FIRST:    cond_match = bof;
      COND_NOTFIRST: cond_match = !bof;
      default:       cond_match = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_packer_v2_if.sv
// Streaming bus of the packer: input vector side and packed output word side.
interface data_packer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
) ();
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                         valid_in;
  logic                         ready_in;
  logic                         eof_in;
  logic                         bof_in;
  logic [CW-1:0]                chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic                         valid_out;
  logic                         ready_out;

  modport slave (
    input  valid_in, eof_in, bof_in, chainId_in, vector_in, ready_out,
    output ready_in, vector_out, valid_out
  );

  modport master (
    output valid_in, eof_in, bof_in, chainId_in, vector_in, ready_out,
    input  ready_in, vector_out, valid_out
  );
endinterface

// File: rtl/data_packer_v2_config_regs.sv
// Per-chain firmware tables (COND/LEN/FLUSH) loaded by a byte stream while
// tracing is off, with a combinational read port for the selected chain.
module packer_config_regs
  import data_packer_pkg::*;
#(
  parameter int        MAX_CHAINS                    = 4,
  parameter cfg_byte_t PERSONAL_CONFIG_ID            = 8'd0,
  parameter cfg_byte_t INITIAL_LEN   [MAX_CHAINS]    = '{default: 8'd8},
  parameter cfg_byte_t INITIAL_COND  [MAX_CHAINS]    = '{default: 8'd0},
  parameter logic      INITIAL_FLUSH [MAX_CHAINS]    = '{default: 1'b0},
  localparam int       CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int       BW = $clog2(3*MAX_CHAINS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_tracing,
  input  cfg_byte_t     i_config_id,
  input  cfg_byte_t     i_config_data,
  input  logic [CW-1:0] i_chain,
  output cfg_byte_t     o_cond,
  output cfg_byte_t     o_len,
  output logic          o_flush
);

  logic [BW-1:0] r_byte_cnt;
  cfg_byte_t     r_cond  [MAX_CHAINS];
  cfg_byte_t     r_len   [MAX_CHAINS];
  logic          r_flush [MAX_CHAINS];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) begin
        r_cond[i]  <= INITIAL_COND[i];
        r_len[i]   <= INITIAL_LEN[i];
        r_flush[i] <= INITIAL_FLUSH[i];
      end
    end else if (!i_tracing) begin
      if (i_config_id == PERSONAL_CONFIG_ID) begin
        // Counter parks at 3*MAX_CHAINS so trailing bytes fall off the end.
        if (r_byte_cnt < BW'(3*MAX_CHAINS))
          r_byte_cnt <= r_byte_cnt + 1'b1;
        for (int i = 0; i < MAX_CHAINS; i++) begin
          if (r_byte_cnt == BW'(i))              r_cond[i]  <= i_config_data;
          if (r_byte_cnt == BW'(MAX_CHAINS+i))   r_len[i]   <= i_config_data;
          if (r_byte_cnt == BW'(2*MAX_CHAINS+i)) r_flush[i] <= i_config_data[0];
        end
      end else begin
        r_byte_cnt <= '0;
      end
    end
  end

  assign o_cond  = r_cond[i_chain];
  assign o_len   = r_len[i_chain];
  assign o_flush = r_flush[i_chain];

endmodule

// File: rtl/data_packer_v2.sv
// Trace data packer: packs LEN-element input vectors into full N-element words,
// with optional zero-padded flush on end-of-frame and valid/ready on both sides.
module data_packer_v2
  import data_packer_pkg::*;
#(
  parameter int        N                             = 8,
  parameter int        DATA_WIDTH                    = 32,
  parameter int        MAX_CHAINS                    = 4,
  parameter cfg_byte_t PERSONAL_CONFIG_ID            = 8'd0,
  parameter cfg_byte_t INITIAL_LEN   [MAX_CHAINS]    = '{default: 8'(N)},
  parameter cfg_byte_t INITIAL_COND  [MAX_CHAINS]    = '{default: 8'd0},
  parameter logic      INITIAL_FLUSH [MAX_CHAINS]    = '{default: 1'b0}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tracing,
  input  cfg_byte_t     configId,
  input  cfg_byte_t     configData,
  data_packer_if.slave  bus
);

  localparam int LW = $clog2(N) + 1;
  localparam int FW = $clog2(2*N) + 1;

  logic [2*N-1:0][DATA_WIDTH-1:0] r_buf;
  logic [2*N-1:0][DATA_WIDTH-1:0] w_in_ext;
  logic [2*N-1:0][DATA_WIDTH-1:0] w_in_shift;
  logic [2*N-1:0][DATA_WIDTH-1:0] w_merged;
  logic [2*N-1:0][DATA_WIDTH-1:0] w_rem;
  logic [N-1:0][DATA_WIDTH-1:0]   r_vec_out;
  logic [FW-1:0]                  r_fill;
  logic [FW-1:0]                  w_new_fill;
  logic [LW-1:0]                  w_len;
  state_t                         r_state;
  logic                           r_valid_out;
  cfg_byte_t                      w_cond;
  cfg_byte_t                      w_len_raw;
  logic                           w_flush_en;
  logic                           w_out_free;
  logic                           w_ready_in;
  logic                           w_accept;
  logic                           w_flush;
  logic                           w_full;
  logic                           w_overflow;

  packer_config_regs #(
    .MAX_CHAINS         (MAX_CHAINS),
    .PERSONAL_CONFIG_ID (PERSONAL_CONFIG_ID),
    .INITIAL_LEN        (INITIAL_LEN),
    .INITIAL_COND       (INITIAL_COND),
    .INITIAL_FLUSH      (INITIAL_FLUSH)
  ) u_cfg (
    .clk           (clk),
    .reset         (reset),
    .i_tracing     (tracing),
    .i_config_id   (configId),
    .i_config_data (configData),
    .i_chain       (bus.chainId_in),
    .o_cond        (w_cond),
    .o_len         (w_len_raw),
    .o_flush       (w_flush_en)
  );

  assign w_len      = (w_len_raw > 8'(N)) ? LW'(N) : LW'(w_len_raw);
  assign w_out_free = !r_valid_out || bus.ready_out;
  assign w_ready_in = tracing && (r_state == RUN) && w_out_free;
  assign w_accept   = bus.valid_in && w_ready_in && (w_len_raw != 8'd0) &&
                      cond_match(w_cond, bus.eof_in, bus.bof_in);
  assign w_flush    = w_accept && w_flush_en && bus.eof_in;
  assign w_new_fill = r_fill + FW'(w_len);
  assign w_full     = (w_new_fill >= FW'(N));
  assign w_overflow = (w_new_fill >  FW'(N));

  // Buffer entries at and above r_fill are kept zero, so placing the input is
  // a shifted OR and flushed words come out already zero-padded.
  always_comb begin
    w_in_ext = '0;
    for (int k = 0; k < N; k++)
      if (k < int'(w_len)) w_in_ext[k] = bus.vector_in[k];
  end

  assign w_in_shift = w_in_ext << (r_fill * DATA_WIDTH);
  assign w_merged   = r_buf | w_in_shift;
  assign w_rem      = w_merged >> (N * DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_valid_out <= 1'b0;
      r_vec_out   <= '0;
      r_buf       <= '0;
      r_fill      <= '0;
    end else begin
      if (r_valid_out && bus.ready_out)
        r_valid_out <= 1'b0;
      if (r_state == TAIL) begin
        if (w_out_free) begin
          r_vec_out   <= r_buf[N-1:0];
          r_valid_out <= 1'b1;
          r_buf       <= '0;
          r_fill      <= '0;
          r_state     <= RUN;
        end
      end else if (w_accept) begin
        if (w_full || w_flush) begin
          r_vec_out   <= w_merged[N-1:0];
          r_valid_out <= 1'b1;
        end
        if (w_flush && !w_overflow) begin
          r_buf  <= '0;
          r_fill <= '0;
        end else if (w_full) begin
          r_buf  <= w_rem;
          r_fill <= w_new_fill - FW'(N);
          if (w_flush) r_state <= TAIL;
        end else begin
          r_buf  <= w_merged;
          r_fill <= w_new_fill;
        end
      end
    end
  end

  assign bus.ready_in   = w_ready_in;
  assign bus.valid_out  = r_valid_out;
  assign bus.vector_out = r_vec_out;

endmodule
